// File: rtl/jump_pkg.sv
// Shared definitions for the branch/jump resolution unit: opcode encodings
// and the constant target table used by branches, jumps and calls.
package jump_pkg;

    // Control-flow opcodes. Encodings 6 and 7 are unused and behave as NOP.
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BNE  = 3'd2,
        OP_JMP  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_t;

    // Number of target-table entries and their stored width.
    localparam int LUT_N = 16;
    localparam int LUT_W = 12;

    // Target table. Branch entries are two's-complement offsets and
    // jump/call entries are absolute addresses. Which is which depends only
    // on the opcode that indexes the entry.
    localparam logic [LUT_W-1:0] LUT [LUT_N] = '{
        12'h000,    // 0
        12'h004,    // 1  short forward offset
        12'h005,    // 2  forward offset
        12'hFFC,    // 3  -4 backward offset
        12'h040,    // 4  subroutine address
        12'h100,    // 5  subroutine address
        12'h200,    // 6
        12'h7F0,    // 7
        12'hFF0,    // 8  high absolute address / -16 offset
        12'h010,    // 9
        12'h800,    // 10
        12'h0FF,    // 11
        12'hABC,    // 12
        12'hF00,    // 13
        12'h123,    // 14
        12'hFFF     // 15 -1 offset
    };

    // True when the opcode is a conditional branch.
    function automatic logic is_branch(input logic [2:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/jump_ctrl_ret_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry while the occupancy count saturates at DEPTH. Popping an
// empty stack must be prevented by the caller. DEPTH is a power of two and
// at least 2 so that the pointer wraps naturally.
import jump_pkg::*;

module ret_stack #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [PC_W-1:0]            din,
    output logic [PC_W-1:0]            top,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; contents are don't-care after reset, so no reset here.
    logic [PC_W-1:0]  mem [DEPTH];

    // sp_q points at the next free slot; the top of stack sits just below it.
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] top_idx;

    assign top_idx = sp_q - PTR_W'(1);
    assign top     = mem[top_idx];
    assign depth   = cnt_q;
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);

    // Pointer and occupancy next state; a simultaneous push and pop
    // replaces the top entry and leaves both unchanged.
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push && !pop) begin
            sp_d = sp_q + PTR_W'(1);
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && !push) begin
            sp_d  = sp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry write: a push lands in the free slot, or over the top entry when
    // it coincides with a pop. Writes are suppressed during reset.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            if (pop) begin
                mem[top_idx] <= din;
            end else begin
                mem[sp_q] <= din;
            end
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Branch/jump resolution unit. Decodes the control-flow op into the PC's
// relative/absolute jump interface in the same cycle, manages the return
// stack for calls and returns, and raises a registered flush after every
// taken redirect.
import jump_pkg::*;

module jump_ctrl #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic [2:0]                 op,
    input  logic [3:0]                 lut_idx,
    input  logic                       zero,
    input  logic [PC_W-1:0]            prog_ctr,
    output logic                       reljump_en,
    output logic                       absjump_en,
    output logic [PC_W-1:0]            target,
    output logic                       flush,
    output logic                       ovf_err,
    output logic                       unf_err,
    output logic [$clog2(DEPTH):0]     depth
);

    // Table entry for this instruction, sign-extended or truncated to PC_W.
    logic [LUT_W-1:0] lut_raw;
    logic [PC_W-1:0]  lut_val;

    assign lut_raw = LUT[lut_idx];
    assign lut_val = PC_W'($signed(lut_raw));

    // Return-stack interface.
    logic             stk_push, stk_pop;
    logic [PC_W-1:0]  stk_din, stk_top;
    logic             stk_full, stk_empty;

    // Sticky error flags and registered flush.
    logic flush_q, flush_d;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    logic active;
    logic taken;

    assign active  = reset && valid;
    assign stk_din = prog_ctr + PC_W'(1);

    ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .top   (stk_top),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Op decode: jump enables, target, stack control and error-flag updates.
    always_comb begin
        reljump_en = 1'b0;
        absjump_en = 1'b0;
        target     = '0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        taken      = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (active) begin
            if (is_branch(op)) begin
                taken = (op == OP_BEQ) ? zero : !zero;
            end

            case (op)
                OP_BEQ, OP_BNE: begin
                    if (taken) begin
                        // Forward offsets go straight to the PC's relative
                        // adder; backward ones are resolved here instead.
                        if (!lut_val[PC_W-1]) begin
                            reljump_en = 1'b1;
                            target     = lut_val;
                        end else begin
                            absjump_en = 1'b1;
                            target     = prog_ctr + lut_val;
                        end
                    end
                end
                OP_JMP: begin
                    absjump_en = 1'b1;
                    target     = lut_val;
                end
                OP_CALL: begin
                    absjump_en = 1'b1;
                    target     = lut_val;
                    stk_push   = 1'b1;
                    if (stk_full) begin
                        ovf_d = 1'b1;
                    end
                end
                OP_RET: begin
                    // An empty stack yields no redirect and leaves the
                    // pointer alone.
                    if (!stk_empty) begin
                        absjump_en = 1'b1;
                        target     = stk_top;
                        stk_pop    = 1'b1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        flush_d = reljump_en || absjump_en;
    end

    // Flush and sticky error registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flush_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flush_q <= flush_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign flush   = flush_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl: directed vectors push their expected
// response into a queue, and a negedge monitor pops and compares.
import jump_pkg::*;

module tb_jump_ctrl;

    localparam int PC_W  = 12;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             valid;
    logic [2:0]       op;
    logic [3:0]       lut_idx;
    logic             zero;
    logic [PC_W-1:0]  prog_ctr;
    logic             reljump_en;
    logic             absjump_en;
    logic [PC_W-1:0]  target;
    logic             flush;
    logic             ovf_err;
    logic             unf_err;
    logic [2:0]       depth;

    typedef struct {
        string            name;
        logic             rel;
        logic             abs;
        logic [PC_W-1:0]  tgt;
        logic             flush;
        logic [2:0]       depth;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    jump_ctrl #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .op         (op),
        .lut_idx    (lut_idx),
        .zero       (zero),
        .prog_ctr   (prog_ctr),
        .reljump_en (reljump_en),
        .absjump_en (absjump_en),
        .target     (target),
        .flush      (flush),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err),
        .depth      (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string field,
                       input logic [PC_W-1:0] act, input logic [PC_W-1:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
        end
    endtask

    // Monitor: every driven cycle presents a response, compared at negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "reljump_en", PC_W'(reljump_en), PC_W'(e.rel));
            chk(e.name, "absjump_en", PC_W'(absjump_en), PC_W'(e.abs));
            chk(e.name, "target",     target,            e.tgt);
            chk(e.name, "flush",      PC_W'(flush),      PC_W'(e.flush));
            chk(e.name, "depth",      PC_W'(depth),      PC_W'(e.depth));
            chk(e.name, "ovf_err",    PC_W'(ovf_err),    PC_W'(e.ovf));
            chk(e.name, "unf_err",    PC_W'(unf_err),    PC_W'(e.unf));
            $display("txn %-10s op=%0d idx=%0d z=%0b pc=%h rst=%0b -> rel=%0b abs=%0b tgt=%h flush=%0b depth=%0d ovf=%0b unf=%0b",
                     e.name, op, lut_idx, zero, prog_ctr, reset, reljump_en,
                     absjump_en, target, flush, depth, ovf_err, unf_err);
        end
    end

    // Drive one cycle of inputs and queue the hand-computed response. The
    // registered expectations are the values visible during this cycle.
    task automatic step(input string name, input logic rst, input logic v,
                        input logic [2:0] o, input logic [3:0] idx,
                        input logic z, input logic [PC_W-1:0] pc,
                        input logic e_rel, input logic e_abs,
                        input logic [PC_W-1:0] e_tgt, input logic e_flush,
                        input logic [2:0] e_depth, input logic e_ovf,
                        input logic e_unf);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        valid    = v;
        op       = o;
        lut_idx  = idx;
        zero     = z;
        prog_ctr = pc;
        e.name  = name;
        e.rel   = e_rel;
        e.abs   = e_abs;
        e.tgt   = e_tgt;
        e.flush = e_flush;
        e.depth = e_depth;
        e.ovf   = e_ovf;
        e.unf   = e_unf;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        valid    = 1'b0;
        op       = OP_NOP;
        lut_idx  = 4'd0;
        zero     = 1'b0;
        prog_ctr = '0;
        repeat (3) @(posedge clk);

        //    name          rst v   op       idx z  pc        rel abs tgt      fl dp ov un
        step("idle",        1, 0, OP_NOP,  0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0);
        step("beq_fwd",     1, 1, OP_BEQ,  2, 1, 12'h010, 1, 0, 12'h005, 0, 0, 0, 0);
        step("beq_nt",      1, 1, OP_BEQ,  2, 0, 12'h010, 0, 0, 12'h000, 1, 0, 0, 0);
        step("idle2",       1, 0, OP_NOP,  0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0);
        step("bne_back",    1, 1, OP_BNE,  3, 0, 12'h010, 0, 1, 12'h00C, 0, 0, 0, 0);
        step("bne_wrap",    1, 1, OP_BNE,  3, 0, 12'h002, 0, 1, 12'hFFE, 1, 0, 0, 0);
        step("bne_nt",      1, 1, OP_BNE,  3, 1, 12'h002, 0, 0, 12'h000, 1, 0, 0, 0);
        step("jmp",         1, 1, OP_JMP,  8, 0, 12'h123, 0, 1, 12'hFF0, 0, 0, 0, 0);
        step("call1",       1, 1, OP_CALL, 5, 0, 12'h020, 0, 1, 12'h100, 1, 0, 0, 0);
        step("ret1",        1, 1, OP_RET,  0, 0, 12'h100, 0, 1, 12'h021, 1, 1, 0, 0);
        step("idle3",       1, 0, OP_NOP,  0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0, 0);
        step("callA",       1, 1, OP_CALL, 5, 0, 12'h010, 0, 1, 12'h100, 0, 0, 0, 0);
        step("callB",       1, 1, OP_CALL, 5, 0, 12'h020, 0, 1, 12'h100, 1, 1, 0, 0);
        step("callC",       1, 1, OP_CALL, 5, 0, 12'h030, 0, 1, 12'h100, 1, 2, 0, 0);
        step("callD",       1, 1, OP_CALL, 5, 0, 12'h040, 0, 1, 12'h100, 1, 3, 0, 0);
        step("callE_ovf",   1, 1, OP_CALL, 5, 0, 12'h050, 0, 1, 12'h100, 1, 4, 0, 0);
        step("retE",        1, 1, OP_RET,  0, 0, 12'h100, 0, 1, 12'h051, 1, 4, 1, 0);
        step("retD",        1, 1, OP_RET,  0, 0, 12'h051, 0, 1, 12'h041, 1, 3, 1, 0);
        step("retC",        1, 1, OP_RET,  0, 0, 12'h041, 0, 1, 12'h031, 1, 2, 1, 0);
        step("retB",        1, 1, OP_RET,  0, 0, 12'h031, 0, 1, 12'h021, 1, 1, 1, 0);
        step("ret_empty",   1, 1, OP_RET,  0, 0, 12'h021, 0, 0, 12'h000, 1, 0, 1, 0);
        step("idle_unf",    1, 0, OP_NOP,  0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 1, 1);
        step("rst_call",    0, 1, OP_CALL, 5, 0, 12'h060, 0, 0, 12'h000, 0, 0, 1, 1);
        step("ret_after",   1, 1, OP_RET,  0, 0, 12'h061, 0, 0, 12'h000, 0, 0, 0, 0);
        step("idle4",       1, 0, OP_NOP,  0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 1);
        step("op6_nop",     1, 1, 3'd6,    5, 1, 12'h033, 0, 0, 12'h000, 0, 0, 0, 1);
        step("op7_nop",     1, 1, 3'd7,    5, 1, 12'h033, 0, 0, 12'h000, 0, 0, 0, 1);
        step("gated_jmp",   1, 0, OP_JMP,  5, 0, 12'h033, 0, 0, 12'h000, 0, 0, 0, 1);
        step("beq_back",    1, 1, OP_BEQ,  3, 1, 12'h010, 0, 1, 12'h00C, 0, 0, 0, 1);
        step("call_wrap",   1, 1, OP_CALL, 4, 0, 12'h7FF, 0, 1, 12'h040, 1, 0, 0, 1);
        step("idle5",       1, 0, OP_NOP,  0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 1);
        step("ret_wrap",    1, 1, OP_RET,  0, 0, 12'h040, 0, 1, 12'h800, 0, 1, 0, 1);
        step("idle6",       1, 0, OP_NOP,  0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0, 1);

        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = OP_NOP;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Branch/jump resolution unit that drives the program counter's jump interface. It takes the decoded control-flow op, the zero flag and the current `prog_ctr`, and produces `reljump_en`, `absjump_en` and `target` in the same cycle, so the PC redirects on the next clock edge. Branch and jump destinations come from a 16-entry target table. Calls and returns go through an internal return-address stack.

## Interface
- `PC_W`, 12, program-counter width; must match the PC block.
- `DEPTH`, 4, return-stack entries; power of two.
- `clk`  input  1  clock; all state updates on posedge.
- `reset`  input  1  synchronous, active-low reset; `reset==0` at posedge clears all state.
- `valid`  input  1  decoded instruction is valid this cycle.
- `op`  input  3  control-flow opcode (`jump_pkg::op_t`).
- `lut_idx`  input  4  target-table index.
- `zero`  input  1  ALU zero flag for conditional branches.
- `prog_ctr`  input  PC_W  current PC value.
- `reljump_en`  output  1  to the PC: relative jump.
- `absjump_en`  output  1  to the PC: absolute jump.
- `target`  output  PC_W  to the PC: offset or address.
- `flush`  output  1  kill the instruction fetched after a taken redirect.
- `ovf_err`  output  1  sticky: a call was made with the stack full.
- `unf_err`  output  1  sticky: a return was made with the stack empty.
- `depth`  output  $clog2(DEPTH)+1  current stack occupancy.

## Operation
- Opcodes:
  - `OP_NOP`=0.
  - `OP_BEQ`=1: taken if `zero`.
  - `OP_BNE`=2: taken if `!zero`.
  - `OP_JMP`=3: always taken.
  - `OP_CALL`=4.
  - `OP_RET`=5.
  - 6 and 7 are treated as NOP.
- Gating: when `valid==0` or `reset==0`, `reljump_en`, `absjump_en` and `target` are all 0.
- Target table: `LUT[i]` is a PC_W-bit constant. For BEQ/BNE it is a two's-complement offset. For JMP/CALL it is an absolute address.
- Taken BEQ/BNE with a non-negative offset (`LUT[i][PC_W-1]==0`): `reljump_en=1`, `target=LUT[i]`.
- Taken BEQ/BNE with a negative offset: `absjump_en=1`, `target=prog_ctr+LUT[i]` mod 2^PC_W.
- Not-taken branch: both enables 0 and `target=0`, so the PC increments.
- JMP: `absjump_en=1`, `target=LUT[i]`.
- CALL: `absjump_en=1`, `target=LUT[i]`. Pushes `prog_ctr+1` (mod 2^PC_W) at the posedge.
- CALL with the stack full: the push overwrites the oldest entry (circular), `depth` stays at DEPTH, and `ovf_err` sets.
- RET with the stack non-empty: `absjump_en=1`, `target=top`. Pops at the posedge.
- RET with the stack empty: no jump (both enables 0), `unf_err` sets, and the pointer is unchanged.
- `reljump_en` and `absjump_en` are never both 1.
- `ovf_err` and `unf_err` stay set until reset.

## Timing
- Enables and `target` are combinational from the inputs and stack state, with zero-cycle latency. The PC acts on them at the same posedge.
- The stack push/pop, `depth` and error flags update at the posedge where the op is valid. A back-to-back CALL then RET returns the just-pushed address.
- `flush` is registered: it is 1 in the cycle after any cycle with `reljump_en|absjump_en`, and 0 otherwise.
- Reset values: `flush=0`, `ovf_err=0`, `unf_err=0`, `depth=0`, stack pointer 0. Stack contents are don't-care.
- Reset during an active op: reset wins. No push or pop happens, and the outputs are 0 in that cycle.

## Structure
- Package `jump_pkg` holds:
  - `op_t` enum with the encodings above;
  - `LUT_N=16`;
  - the target-table contents as a localparam array.
- Sub-module `ret_stack`: circular LIFO with parameters `PC_W` and `DEPTH`.
  - Ports: `clk`, `reset`, `push`, `pop`, `din`, `top`, `depth`, `full`, `empty`.
  - On full push: overwrite the oldest entry, with `depth` saturating.
  - The pop-when-empty guard lives in `jump_ctrl`.

## Test plan
- Reset, then idle with `valid=0` → `depth=0`, `flush=0`, errors 0, enables 0.
- BEQ with `zero=1`, `LUT[2]=12'h005`, `prog_ctr=12'h010` → `reljump_en=1`, `target=12'h005`, and `flush=1` next cycle. Same op with `zero=0` → no enables, no flush.
- BNE with `zero=0`, `LUT[3]=12'hFFC` (−4), `prog_ctr=12'h010` → `absjump_en=1`, `target=12'h00C`. Also `prog_ctr=12'h002` → `target=12'hFFE` (wrap).
- CALL at `prog_ctr=12'h020` with `LUT[5]=12'h100`, then RET → `target=12'h100`, then `target=12'h021`, with `depth` going 1 then 0.
- Five CALLs from `prog_ctr` = 0x10, 0x20, 0x30, 0x40, 0x50 with DEPTH=4 → `ovf_err=1` and `depth=4`. Four RETs then return 0x51, 0x41, 0x31, 0x21. A fifth RET → `unf_err=1` and no jump.
- Drive reset low in the same cycle as a CALL → no push, `depth=0`, enables 0. After release, a RET → `unf_err=1`.
